// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of an 8-bit asynchronous SRAM. Each 32-bit
// master access is split into byte accesses with programmable strobe width.
module sram_arbiter #(
  parameter int ACC_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [16:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [16:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        sram_ce_bar,
  output logic        sram_oe_bar,
  output logic        sram_we_bar,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dout,
  output logic        sram_doe,
  input  logic [7:0]  sram_din
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER, ACK} state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACC_CYC - 1);

  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] k,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{k, 3'b000} +: 8] = b;
    return r;
  endfunction

  // Control state (asynchronously reset)
  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [3:0]  rem_q, rem_d;
  logic [1:0]  lane_q, lane_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ce_bar_q, ce_bar_d;
  logic        oe_bar_q, oe_bar_d;
  logic        we_bar_q, we_bar_d;
  logic        doe_q, doe_d;
  logic [18:0] saddr_q, saddr_d;
  logic [7:0]  dout_q, dout_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  // Latched transaction fields and read assembly buffer (no reset needed)
  logic        we_q, we_d;
  logic [16:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        sel;
  logic        start;
  logic [3:0]  src_mask;
  logic [1:0]  byte_lane;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    rem_d     = rem_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    ce_bar_d  = ce_bar_q;
    oe_bar_d  = oe_bar_q;
    we_bar_d  = we_bar_q;
    doe_d     = doe_q;
    saddr_d   = saddr_q;
    dout_d    = dout_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rbuf_d    = rbuf_q;
    sel       = 1'b0;
    start     = 1'b0;
    src_mask  = 4'b0000;
    byte_lane = 2'd0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // Contention goes to whoever did not win last time.
          sel     = (m0_req && m1_req) ? ~last_q : m1_req;
          gnt_d   = sel;
          last_d  = sel;
          we_d    = sel ? m1_we    : m0_we;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          if (we_d) src_mask = sel ? m1_be : m0_be;
          else      src_mask = 4'b1111;
          if (src_mask == 4'b0000) begin
            state_d = ACK;
            ack0_d  = ~sel;
            ack1_d  = sel;
          end else begin
            start = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (!we_q) rbuf_d = put_byte(rbuf_q, lane_q, sram_din);
          if (rem_q == 4'b0000) begin
            state_d  = ACK;
            ce_bar_d = 1'b1;
            oe_bar_d = 1'b1;
            we_bar_d = 1'b1;
            doe_d    = 1'b0;
            ack0_d   = ~gnt_q;
            ack1_d   = gnt_q;
            if (!we_q) begin
              if (gnt_q) rdata1_d = rbuf_d;
              else       rdata0_d = rbuf_d;
            end
          end else begin
            // Address and write data stay put across the gap.
            state_d  = RECOVER;
            oe_bar_d = 1'b1;
            we_bar_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RECOVER: begin
        start    = 1'b1;
        src_mask = rem_q;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      byte_lane = first_lane(src_mask);
      rem_d     = src_mask & ~(4'b0001 << byte_lane);
      lane_d    = byte_lane;
      cnt_d     = 4'd0;
      state_d   = ACCESS;
      ce_bar_d  = 1'b0;
      oe_bar_d  = we_d;
      we_bar_d  = ~we_d;
      doe_d     = we_d;
      saddr_d   = {addr_d, byte_lane};
      if (we_d) dout_d = lane_byte(wdata_d, byte_lane);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      rem_q    <= 4'b0000;
      lane_q   <= 2'd0;
      cnt_q    <= 4'd0;
      ce_bar_q <= 1'b1;
      oe_bar_q <= 1'b1;
      we_bar_q <= 1'b1;
      doe_q    <= 1'b0;
      saddr_q  <= 19'd0;
      dout_q   <= 8'd0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      ce_bar_q <= ce_bar_d;
      oe_bar_q <= oe_bar_d;
      we_bar_q <= we_bar_d;
      doe_q    <= doe_d;
      saddr_q  <= saddr_d;
      dout_q   <= dout_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rbuf_q  <= rbuf_d;
  end

  assign m0_ack      = ack0_q;
  assign m1_ack      = ack1_q;
  assign m0_rdata    = rdata0_q;
  assign m1_rdata    = rdata1_q;
  assign sram_ce_bar = ce_bar_q;
  assign sram_oe_bar = oe_bar_q;
  assign sram_we_bar = we_bar_q;
  assign sram_addr   = saddr_q;
  assign sram_dout   = dout_q;
  assign sram_doe    = doe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reads, masked writes, round-robin,
// zero-mask writes and reset in the middle of a write strobe.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [16:0] m0_addr = '0;
  logic [31:0] m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [16:0] m1_addr = '0;
  logic [31:0] m1_wdata = '0;
  logic [3:0]  m1_be = '0;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic        sram_ce_bar, sram_oe_bar, sram_we_bar, sram_doe;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic [7:0]  din_base = 8'h00;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int ce_low = 0;
  logic [26:0] wlog[$];
  logic [18:0] rlog[$];

  assign sram_din = din_base + {6'b0, sram_addr[1:0]};

  always #5 clk = ~clk;

  sram_arbiter #(.ACC_CYC(2)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_be(m0_be), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_be(m1_be), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .sram_ce_bar(sram_ce_bar), .sram_oe_bar(sram_oe_bar), .sram_we_bar(sram_we_bar),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int m, input logic we, input logic [16:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be; m1_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input int m, input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if ((m == 0) ? m0_ack : m1_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  // Bus-wide invariants and strobe logs, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("ack_excl", m0_ack & m1_ack, 0);
      chk("oe_we_excl", !sram_oe_bar && !sram_we_bar, 0);
      if (!sram_ce_bar) ce_low++;
      if (!sram_we_bar) wlog.push_back({sram_addr, sram_dout});
      if (!sram_oe_bar) rlog.push_back(sram_addr);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ce0;
    int order[$];
    logic [26:0] exp_w [4];
    logic [7:0]  dead [4];
    exp_w[0] = {19'h48D, 8'h33};
    exp_w[1] = {19'h48D, 8'h33};
    exp_w[2] = {19'h48F, 8'h11};
    exp_w[3] = {19'h48F, 8'h11};
    dead[0] = 8'hEF; dead[1] = 8'hBE; dead[2] = 8'hAD; dead[3] = 8'hDE;

    #1 rst = 1'b1;
    #2;
    chk("rst_ce", sram_ce_bar, 1);
    chk("rst_oe", sram_oe_bar, 1);
    chk("rst_we", sram_we_bar, 1);
    chk("rst_doe", sram_doe, 0);
    chk("rst_ack0", m0_ack, 0);
    chk("rst_ack1", m1_ack, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dout", sram_dout, 0);
    chk("rst_rdata0", m0_rdata, 0);
    chk("rst_rdata1", m1_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // m0 full-word read
    @(negedge clk);
    din_base = 8'hA0;
    rlog.delete();
    issue(0, 1'b0, 17'h00010, 32'h0, 4'h0);
    wait_ack(0, 40, lat);
    m0_req = 1'b0;
    chk("rd_lat", lat, 12);
    chk("rd_data", m0_rdata, 32'hA3A2A1A0);
    chk("rd_ack_ce", sram_ce_bar, 1);
    chk("rd_ack_oe", sram_oe_bar, 1);
    chk("rd_ack_doe", sram_doe, 0);
    chk("rd_other_ack", m1_ack, 0);
    @(posedge clk); #1;
    chk("rd_ack_pulse", m0_ack, 0);
    chk("rd_log_len", rlog.size(), 8);
    for (int i = 0; i < 8 && i < rlog.size(); i++)
      chk("rd_addr", rlog[i], 19'h40 + 19'(i / 2));

    // m1 masked write
    @(negedge clk);
    wlog.delete();
    issue(1, 1'b1, 17'h00123, 32'h11223344, 4'b1010);
    wait_ack(1, 40, lat);
    m1_req = 1'b0;
    chk("wr_lat", lat, 6);
    chk("wr_ack_doe", sram_doe, 0);
    @(posedge clk); #1;
    chk("wr_ack_pulse", m1_ack, 0);
    chk("wr_keep_rdata0", m0_rdata, 32'hA3A2A1A0);
    chk("wr_log_len", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk("wr_lane", wlog[i], exp_w[i]);

    // write with no byte enables
    @(negedge clk);
    ce0 = ce_low;
    issue(0, 1'b1, 17'h00055, 32'hFFFFFFFF, 4'b0000);
    wait_ack(0, 10, lat);
    m0_req = 1'b0;
    chk("be0_lat", lat, 1);
    chk("be0_we", sram_we_bar, 1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("be0_no_strobe", ce_low, ce0);
    chk("be0_keep_rdata0", m0_rdata, 32'hA3A2A1A0);

    // simultaneous requests out of reset, both held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rr_rdata_cleared", m0_rdata, 0);
    din_base = 8'h50;
    issue(0, 1'b0, 17'h00001, 32'h0, 4'h0);
    issue(1, 1'b0, 17'h00002, 32'h0, 4'h0);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m0_ack) order.push_back(0);
      if (m1_ack) order.push_back(1);
      if (order.size() >= 3) break;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("rr_count", order.size(), 3);
    if (order.size() >= 3) begin
      chk("rr_first", order[0], 0);
      chk("rr_second", order[1], 1);
      chk("rr_third", order[2], 0);
    end
    chk("rr_rdata0", m0_rdata, 32'h53525150);
    chk("rr_rdata1", m1_rdata, 32'h53525150);
    @(posedge clk); #1;

    // reset while a write strobe is low
    @(negedge clk);
    issue(1, 1'b1, 17'h00007, 32'hDEADBEEF, 4'b1111);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!sram_we_bar) begin
        lat = i;
        break;
      end
    end
    chk("rstw_saw_we", lat, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstw_we", sram_we_bar, 1);
    chk("rstw_doe", sram_doe, 0);
    chk("rstw_ce", sram_ce_bar, 1);
    chk("rstw_addr", sram_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rstw_no_ack", m1_ack, 0);
    @(negedge clk);
    rst = 1'b0;
    wlog.delete();
    wait_ack(1, 40, lat);
    m1_req = 1'b0;
    chk("rstw_lat", lat, 12);
    @(posedge clk); #1;
    chk("rstw_log_len", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++)
      chk("rstw_lane", wlog[i], {19'h1C + 19'(i / 2), dead[i / 2]});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
